// File: rtl/cmp_rgb_pkg.sv
// Shared types for the two-requester RGB comparator scheduler.
// Optional build macro used by the top: CMP_RGB_STICKY_LED_EN.
package cmp_rgb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic r;  // a > b
        logic g;  // a == b
        logic b;  // a < b
    } rgb_t;

endpackage : cmp_rgb_pkg

// File: rtl/cmp_rgb_core.sv
// Combinational unsigned magnitude comparator producing a one-hot R/G/B code.
module cmp_rgb_core
    import cmp_rgb_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output rgb_t             rgb_o
);

    always_comb begin
        rgb_o.r = (a_i > b_i);
        rgb_o.g = (a_i == b_i);
        rgb_o.b = (a_i < b_i);
    end

endmodule : cmp_rgb_core

// File: rtl/cmp_rgb_scheduler.sv
// Round-robin scheduler sharing one comparator and RGB LED between two requesters.
// Define CMP_RGB_STICKY_LED_EN to keep the last R/G/B result visible through IDLE.
module cmp_rgb_scheduler
    import cmp_rgb_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             R,
    output logic             G,
    output logic             B,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             busy
);

`ifdef CMP_RGB_STICKY_LED_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_idx_t         rr_q, rr_d;          // index granted most recently
    logic             rr_seen_q, rr_seen_d; // any grant since reset; req0 wins ties until then
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    req_idx_t         id_q, id_d;
    rgb_t             rgb_q, rgb_d;
    logic             resp_valid_q, resp_valid_d;
    req_idx_t         grant;
    rgb_t             cmp_rgb;

    cmp_rgb_core #(.WIDTH(WIDTH)) u_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .rgb_o (cmp_rgb)
    );

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        rr_seen_d    = rr_seen_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rgb_d        = rgb_q;
        resp_valid_d = 1'b0;
        grant        = '0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!STICKY) rgb_d = '0;
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) grant = rr_seen_q ? ~rr_q : '0;
                    else                          grant = req1_valid;
                    req0_ready = (grant == 1'b0);
                    req1_ready = (grant == 1'b1);
                    a_d        = grant ? req1_a : req0_a;
                    b_d        = grant ? req1_b : req0_b;
                    id_d       = grant;
                    rr_d       = grant;
                    rr_seen_d  = 1'b1;
                    state_d    = CMP;
                end
            end
            CMP: begin
                rgb_d        = cmp_rgb;
                resp_valid_d = 1'b1;
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (!STICKY) rgb_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_q         <= '0;
            rr_seen_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rgb_q        <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            rr_seen_q    <= rr_seen_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rgb_q        <= rgb_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign R          = rgb_q.r;
    assign G          = rgb_q.g;
    assign B          = rgb_q.b;
    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

endmodule : cmp_rgb_scheduler
